product_bcd_display: RTL and testbench

//  Downstream stage of the 4x4 shift-add multiplier. Accepts the 8-bit product,

---
 rtl/prod_disp_pkg.sv | 38 +++
 rtl/seven_seg_decoder.sv | 33 +++
 rtl/product_bcd_display.sv | 172 +++++++++++++++++
 tb/tb_product_bcd_display.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_disp_pkg.sv
// Shared constants for the product-to-BCD display stage: FSM encodings,
// datapath sizes, seven-segment patterns and the double-dabble nibble fix-up.
package prod_disp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int BCD_DIGITS = 3;
    localparam int PROD_W     = 8;
    localparam logic [2:0] SHIFT_CNT_MAX = 3'd7;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, lit segment = 1
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Double-dabble correction: a nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to seven-segment pattern (active-high).
// Codes above 9 and an asserted blank both produce an unlit digit.
module seven_seg_decoder
    import prod_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] pattern
);

    // Look up the lit-segment pattern for the selected digit
    always_comb begin
        pattern = SEG_BLANK;
        if (blank) begin
            pattern = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/product_bcd_display.sv
// Takes an 8-bit product, converts it to three BCD digits with a sequential
// double-dabble engine and scans the result onto a 3-digit seven-segment
// display with leading-zero blanking. The shown value holds until the next
// conversion completes.
module product_bcd_display
    import prod_disp_pkg::*;
#(
    parameter int REFRESH_BITS   = 16,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [11:0]       bcd,
    output logic [6:0]        seg,
    output logic [2:0]        an
);

    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [REFRESH_BITS-1:0] SCAN_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [1:0]              state_r;
    logic [PROD_W-1:0]       bin_r;
    logic [11:0]             scratch_r;
    logic [2:0]              cnt_r;
    logic [11:0]             bcd_r;
    logic                    done_r;
    logic [REFRESH_BITS-1:0] cnt_scan_r;
    logic [1:0]              idx_r;
    logic [2:0]              an_r;
    logic [6:0]              seg_r;

    logic [11:0]             adj_s;
    logic [11:0]             scratch_next_s;
    logic [PROD_W-1:0]       bin_next_s;
    logic [1:0]              idx_next_s;
    logic [2:0]              an_next_s;
    logic [3:0]              digit_sel_s;
    logic                    blank_sel_s;
    logic [6:0]              pattern_s;
    logic [6:0]              seg_next_s;

    assign in_ready = (state_r == ST_IDLE);
    assign busy     = (state_r == ST_SHIFT) || (state_r == ST_DONE);
    assign done     = done_r;
    assign bcd      = bcd_r;
    assign seg      = seg_r;
    assign an       = an_r;

    // One double-dabble step: fix up every nibble, then shift {scratch,bin} left
    always_comb begin
        adj_s          = {dd_adjust(scratch_r[11:8]), dd_adjust(scratch_r[7:4]),
                          dd_adjust(scratch_r[3:0])};
        scratch_next_s = {adj_s[10:0], bin_r[PROD_W-1]};
        bin_next_s     = {bin_r[PROD_W-2:0], 1'b0};
    end

    // Conversion FSM; the result and done pulse are registered on the final shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            bin_r     <= {PROD_W{1'b0}};
            scratch_r <= 12'h000;
            cnt_r     <= 3'd0;
            bcd_r     <= 12'h000;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (in_valid) begin
                        bin_r     <= in_data;
                        scratch_r <= 12'h000;
                        cnt_r     <= 3'd0;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_r <= scratch_next_s;
                    bin_r     <= bin_next_s;
                    cnt_r     <= cnt_r + 3'd1;
                    if (cnt_r == SHIFT_CNT_MAX) begin
                        bcd_r   <= scratch_next_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Select the next digit to scan and its blanking condition
    always_comb begin
        idx_next_s  = 2'd0;
        an_next_s   = 3'b001;
        digit_sel_s = bcd_r[3:0];
        blank_sel_s = 1'b0;
        case (idx_r)
            2'd0:    idx_next_s = 2'd1;
            2'd1:    idx_next_s = 2'd2;
            2'd2:    idx_next_s = 2'd0;
            default: idx_next_s = 2'd0;
        endcase
        case (idx_next_s)
            2'd0: begin
                an_next_s   = 3'b001;
                digit_sel_s = bcd_r[3:0];
                blank_sel_s = 1'b0;
            end
            2'd1: begin
                an_next_s   = 3'b010;
                digit_sel_s = bcd_r[7:4];
                blank_sel_s = (bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0);
            end
            2'd2: begin
                an_next_s   = 3'b100;
                digit_sel_s = bcd_r[11:8];
                blank_sel_s = (bcd_r[11:8] == 4'd0);
            end
            default: begin
                an_next_s   = 3'b001;
                digit_sel_s = bcd_r[3:0];
                blank_sel_s = 1'b0;
            end
        endcase
    end

    seven_seg_decoder u_dec (
        .digit   (digit_sel_s),
        .blank   (blank_sel_s),
        .pattern (pattern_s)
    );

    // Apply board segment polarity
    always_comb begin
        if (SEG_ACTIVE_LOW != 0) begin
            seg_next_s = ~pattern_s;
        end else begin
            seg_next_s = pattern_s;
        end
    end

    // Free-running scan counter; the displayed digit advances on every wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_scan_r <= {REFRESH_BITS{1'b0}};
            idx_r      <= 2'd0;
            an_r       <= 3'b000;
            seg_r      <= SEG_OFF;
        end else begin
            cnt_scan_r <= cnt_scan_r + SCAN_ONE;
            if (&cnt_scan_r) begin
                idx_r <= idx_next_s;
                an_r  <= an_next_s;
                seg_r <= seg_next_s;
            end
        end
    end

endmodule

// File: tb/tb_product_bcd_display.sv
// Randomized self-checking bench for product_bcd_display with a short scan
// period; a second instance exercises the active-low segment polarity.
module tb_product_bcd_display;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, busy, done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        in_ready2, busy2, done2;
    logic [11:0] bcd2;
    logic [6:0]  seg2;
    logic [2:0]  an2;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    product_bcd_display #(.REFRESH_BITS(2), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .bcd(bcd),
        .seg(seg), .an(an)
    );

    product_bcd_display #(.REFRESH_BITS(2), .SEG_ACTIVE_LOW(1)) dut_low (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .busy(busy2), .done(done2), .bcd(bcd2),
        .seg(seg2), .an(an2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int pos, input bit low);
        int h, t, o, d;
        bit blank;
        logic [6:0] pat;
        h = v / 100; t = (v / 10) % 10; o = v % 10;
        d = (pos == 2) ? h : ((pos == 1) ? t : o);
        blank = ((pos == 2) && (h == 0)) || ((pos == 1) && (h == 0) && (t == 0));
        pat = blank ? 7'h00 : SEG_TBL[d];
        return low ? ~pat : pat;
    endfunction

    function automatic int an_pos(input logic [2:0] a);
        return (a == 3'b100) ? 2 : ((a == 3'b010) ? 1 : 0);
    endfunction

    task automatic do_convert(input int v, input string name);
        int k;
        bit seen;
        logic [11:0] exp_bcd;
        exp_bcd = model_bcd(v);
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_timeout in_ready=%b want 1", name, in_ready);
            return;
        end
        in_valid = 1'b1; in_data = 8'(v);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_phase cyc=%0d in_ready=%b busy=%b want 0/1", name, k, in_ready, busy);
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || k != 9) begin
            errors++; $display("FAIL %s latency got=%0d want 9 (seen=%b)", name, k, seen);
        end
        checks++;
        if (bcd !== exp_bcd) begin
            errors++; $display("FAIL %s bcd got=%h want %h", name, bcd, exp_bcd);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || bcd !== exp_bcd) begin
            errors++;
            $display("FAIL %s after_done done=%b in_ready=%b busy=%b bcd=%h want 0/1/0/%h",
                     name, done, in_ready, busy, bcd, exp_bcd);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = 8'h00;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (seg2 !== 7'h7F || an2 !== 3'b000) begin
            errors++; $display("FAIL reset_low_polarity seg2=%h an2=%b want 7f/000", seg2, an2);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 ||
            an !== 3'b000 || seg !== 7'h00) begin
            errors++;
            $display("FAIL reset_state rdy=%b busy=%b done=%b bcd=%h an=%b seg=%h want 1/0/0/000/000/00",
                     in_ready, busy, done, bcd, an, seg);
        end
    endtask

    task automatic test_polarity();
        int lit;
        lit = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (an2 !== 3'b000) begin
                lit++;
                checks++;
                if (seg2 !== model_seg(0, an_pos(an2), 1'b1)) begin
                    errors++;
                    $display("FAIL polarity an2=%b seg2=%h want %h", an2, seg2,
                             model_seg(0, an_pos(an2), 1'b1));
                end
            end
        end
        checks++;
        if (lit < 8) begin errors++; $display("FAIL polarity_lit got=%0d want >=8", lit); end
    endtask

    task automatic test_mid_reset();
        int k;
        do_convert(77, "pre_reset");
        in_valid = 1'b1; in_data = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || an !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset rdy=%b busy=%b done=%b bcd=%h an=%b want 1/0/0/000/000",
                     in_ready, busy, done, bcd, an);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (k = 0; k < 14; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || bcd !== 12'h000) begin
                errors++; $display("FAIL mid_reset_nodone cyc=%0d done=%b bcd=%h want 0/000", k, done, bcd);
            end
        end
    endtask

    task automatic test_boundaries();
        int vals [4] = '{9, 10, 99, 100};
        foreach (vals[i]) do_convert(vals[i], "boundary");
        do_convert(225, "max225");
        do_convert(255, "v255");
        do_convert(0, "zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) do_convert(int'($urandom_range(0, 255)), "random");
    endtask

    task automatic test_back_to_back();
        int dones;
        int first_k;
        logic [11:0] got [2];
        dones = 0; first_k = 0;
        while (in_ready !== 1'b1) @(negedge clk);
        in_valid = 1'b1; in_data = 8'd42;
        @(negedge clk);
        in_data = 8'd0;
        for (int k = 1; k <= 30; k++) begin
            if (done === 1'b1) begin
                if (dones < 2) got[dones] = bcd;
                if (dones == 0) first_k = k;
                dones++;
                if (dones == 2) begin
                    in_valid = 1'b0;
                    checks++;
                    if (k - first_k != 10) begin
                        errors++; $display("FAIL b2b_spacing got=%0d want 10", k - first_k);
                    end
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (dones != 2) begin errors++; $display("FAIL b2b_done_count got=%0d want 2", dones); end
        checks++;
        if (first_k != 9) begin errors++; $display("FAIL b2b_first_latency got=%0d want 9", first_k); end
        if (dones >= 2) begin
            checks++;
            if (got[0] !== 12'h042 || got[1] !== 12'h000) begin
                errors++; $display("FAIL b2b_results got=%h,%h want 042,000", got[0], got[1]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_scan(input int v, input string name);
        int last, changes;
        logic [2:0] prev_an;
        last = -1; changes = 0;
        repeat (6) @(negedge clk);
        prev_an = an;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (an !== prev_an) begin
                changes++;
                checks++;
                if (an !== {prev_an[1:0], prev_an[2]}) begin
                    errors++; $display("FAIL %s scan_order got=%b prev=%b", name, an, prev_an);
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != 4) begin
                        errors++; $display("FAIL %s scan_period got=%0d want 4", name, c - last);
                    end
                end
                last = c;
                checks++;
                if (seg !== model_seg(v, an_pos(an), 1'b0)) begin
                    errors++;
                    $display("FAIL %s scan_seg an=%b got=%h want %h", name, an, seg,
                             model_seg(v, an_pos(an), 1'b0));
                end
                prev_an = an;
            end
        end
        checks++;
        if (changes < 6) begin errors++; $display("FAIL %s scan_changes got=%0d want >=6", name, changes); end
    endtask

    task automatic test_scan();
        do_convert(105, "scan105");
        check_scan(105, "scan105");
        do_convert(7, "scan007");
        check_scan(7, "scan007");
        do_convert(int'($urandom_range(0, 225)), "scanrand");
        check_scan(int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]), "scanrand");
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_polarity();
        do_convert(225, "first225");
        test_mid_reset();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
